disp_chain: RTL and testbench
=============================

# disp_chain

Parametrised serial driver for a chain of N_DEV TLC59282 16-channel LED drivers. It sits between the display frame source (time/status renderer) and the board pins. It double-buffers one frame of 16*N_DEV segment bits, shifts the active frame out on every refresh tick, and latches it. It also generates first-order sigma-delta (PDM) brightness on the BLANK line. It generalises the fixed-length display shifter to any chain length, sclk rate and brightness width, and adds a frame handshake and overrun reporting.

## Interface
Parameters:
- N_DEV, 4, number of chained TLC59282 devices; frame width FW = 16*N_DEV bits
- SCLK_DIV, 2, clk cycles per sclk half-period (>= 1)
- PDM_W, 8, brightness word width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tsc_1ppus  in  1  refresh tick, one-cycle pulse
- disp_ena  in  1  display enable
- disp_pdm  in  PDM_W  brightness, duty = disp_pdm / 2^PDM_W
- frm_data  in  FW  new frame; bit FW-1 goes to the far end of the chain
- frm_valid  in  1  frame offer
- frm_ready  out  1  shadow buffer empty
- disp_sclk  out  1  serial clock to TLC59282
- disp_sin  out  1  serial data
- disp_lat  out  1  latch pulse
- disp_blank  out  1  1 = outputs off
- busy  out  1  shift or latch in progress
- ovr  out  1  one-cycle pulse: tick arrived while busy

## Operation
- Reset values:
  - disp_sclk=0, disp_sin=0, disp_lat=0, disp_blank=1, frm_ready=1, busy=0, ovr=0.
  - Active and shadow buffers are all zero; PDM accumulator is 0; state is IDLE.
- Handshake:
  - A frame is accepted when frm_valid & frm_ready. Shadow <= frm_data and pend <= 1.
  - frm_ready = ~pend.
- Frame start: a tick while IDLE & disp_ena.
  - If pend: active <= shadow and pend <= 0, so frm_ready returns 1 in the next cycle.
  - Otherwise the unchanged active frame is re-sent as a refresh.
- Accept and start in the same cycle (only possible with pend=0): the start sends the old active frame; the new frame stays pending for the next tick.
- States:
  - IDLE -> SHIFT on a frame start.
  - SHIFT: FW bits, MSB first. Each bit is SCLK_DIV cycles with sclk=0 (sin stable), then SCLK_DIV cycles with sclk=1. After the last high phase -> LATCH.
  - LATCH: sclk=0, lat=1 for SCLK_DIV cycles, then -> IDLE with lat=0.
- Tick while busy: the tick is ignored and ovr pulses for 1 cycle. The in-progress frame is unaffected.
- disp_ena low: new ticks are ignored and blank is forced to 1. A frame already in progress completes.
- Reset mid-frame: all outputs go to their reset values immediately; a pending shadow frame is discarded.
- Bit counter width: $clog2(FW); no wrap beyond FW-1.

## Timing
- Tick at cycle T in IDLE:
  - busy=1 and sin=bit FW-1 from T+1.
  - First sclk rise at T+1+SCLK_DIV.
  - sin changes only together with an sclk fall, giving SCLK_DIV cycles of setup and hold.
- busy duration per frame: 2*SCLK_DIV*FW + SCLK_DIV cycles. For the defaults: 2*2*64 + 2 = 258.
- The next tick is accepted in the first cycle after busy falls.
- All outputs are registered; no combinational path from input to pin.

## Configuration
- DISP_PDM_EN defined:
  - {carry, acc} = acc + disp_pdm every clk.
  - disp_blank <= ~carry | ~disp_ena.
  - Exactly disp_pdm unblanked cycles per 2^PDM_W cycles, starting from acc=0.
- DISP_PDM_EN undefined:
  - No accumulator is built and disp_pdm is ignored.
  - disp_blank <= ~disp_ena, registered.

## Structure
- Shared package types_pkg: TLC_CH = 16 (channels per device); state enum disp_chain_st_t {IDLE, SHIFT, LATCH}.
- Sub-module pdm_gen (parameter PDM_W; ports clk, rst_n, ena, level, out) holds the accumulator. It is instantiated only under DISP_PDM_EN.

## Test plan
- Reset release, defaults, frm_data=64'h0123_4567_89AB_CDEF, valid 1 cycle, then one tick:
  - frm_ready falls, then rises 1 cycle after the tick.
  - The bit sequence captured on sclk rising edges equals 0x0123456789ABCDEF, MSB first.
  - lat is high for 2 cycles; busy lasts 258 cycles.
- No new frame and a second tick after busy falls: the identical 64 bits are re-sent.
- Tick at cycle 100 of a frame: ovr high for exactly 1 cycle; the frame continues and its bit stream is unchanged.
- New frame offered while pend=1: frm_ready=0 and the frame is not accepted until the next frame start.
- DISP_PDM_EN defined, disp_pdm=8'haa, disp_ena=1: 170 cycles with blank=0 per 256-cycle window. With 8'h00, blank is always 1. With 8'h80, blank alternates every cycle.
- rst_n asserted mid-shift: in the same cycle sclk=0, lat=0, blank=1 and busy=0. After release, frm_ready=1 and nothing is shifted without a tick.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the TLC59282 chain driver: channel count per device and FSM states.
package types_pkg;

  localparam int TLC_CH = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } disp_chain_st_t;

endpackage

// File: rtl/pdm_gen.sv
// First-order sigma-delta modulator: the carry of acc + level is high for exactly
// level cycles out of every 2^PDM_W.
module pdm_gen #(
  parameter int PDM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [PDM_W-1:0] level,
  output logic             out
);

  logic [PDM_W-1:0] r_acc;
  logic [PDM_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, level};
  assign out   = w_sum[PDM_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (ena) begin
      r_acc <= w_sum[PDM_W-1:0];
    end
  end

endmodule

// File: rtl/disp_chain.sv
// Serial driver for a chain of N_DEV TLC59282 devices: double-buffered frame, shift/latch
// on each refresh tick, overrun reporting. Define DISP_PDM_EN for PDM brightness on BLANK.
module disp_chain
  import types_pkg::*;
#(
  parameter int N_DEV    = 4,
  parameter int SCLK_DIV = 2,
  parameter int PDM_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tsc_1ppus,
  input  logic                  disp_ena,
  input  logic [PDM_W-1:0]      disp_pdm,
  input  logic [TLC_CH*N_DEV-1:0] frm_data,
  input  logic                  frm_valid,
  output logic                  frm_ready,
  output logic                  disp_sclk,
  output logic                  disp_sin,
  output logic                  disp_lat,
  output logic                  disp_blank,
  output logic                  busy,
  output logic                  ovr
);

  localparam int FW    = TLC_CH * N_DEV;
  localparam int BIT_W = $clog2(FW);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  disp_chain_st_t r_state, w_state_nxt;

  logic [FW-1:0]    r_shadow, r_active;
  logic             r_pend;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_phase, w_phase_nxt;
  logic [BIT_W-1:0] r_bit, w_bit_nxt, w_bit_dec;
  logic             r_sclk, w_sclk_nxt;
  logic             r_sin, w_sin_nxt;
  logic             r_lat, w_lat_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_ovr;
  logic             r_blank;
  logic             w_blank_nxt;

  logic             w_start, w_accept, w_div_last;
  logic [FW-1:0]    w_frame;

  assign w_start    = tsc_1ppus & disp_ena & (r_state == IDLE);
  assign w_accept   = frm_valid & ~r_pend;
  assign w_frame    = r_pend ? r_shadow : r_active;
  assign w_div_last = (r_div == DIV_W'(SCLK_DIV - 1));
  assign w_bit_dec  = r_bit - BIT_W'(1);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_sclk_nxt  = r_sclk;
    w_sin_nxt   = r_sin;
    w_lat_nxt   = 1'b0;
    w_busy_nxt  = r_busy;

    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = SHIFT;
          w_div_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_bit_nxt   = BIT_W'(FW - 1);
          w_sclk_nxt  = 1'b0;
          w_sin_nxt   = w_frame[FW-1];
          w_busy_nxt  = 1'b1;
        end
      end

      SHIFT: begin
        if (!w_div_last) begin
          w_div_nxt = r_div + DIV_W'(1);
        end else begin
          w_div_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
            w_sclk_nxt  = 1'b1;
          end else begin
            w_phase_nxt = 1'b0;
            w_sclk_nxt  = 1'b0;
            if (r_bit == '0) begin
              w_state_nxt = LATCH;
              w_lat_nxt   = 1'b1;
            end else begin
              // sin only moves on the sclk fall, giving a full half-period of setup and hold
              w_bit_nxt = w_bit_dec;
              w_sin_nxt = r_active[w_bit_dec];
            end
          end
        end
      end

      LATCH: begin
        if (w_div_last) begin
          w_state_nxt = IDLE;
          w_div_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
          w_lat_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_sclk  <= 1'b0;
      r_sin   <= 1'b0;
      r_lat   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
      r_blank <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sin   <= w_sin_nxt;
      r_lat   <= w_lat_nxt;
      r_busy  <= w_busy_nxt;
      r_ovr   <= tsc_1ppus & r_busy;
      r_blank <= w_blank_nxt;
    end
  end

  // NOTE: the frame buffers are reset because a refresh before the first frame must send zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shadow <= frm_data;
      end
      // accept and start are exclusive when pend=1, so the new frame waits for the next tick
      if (w_start && r_pend) begin
        r_active <= r_shadow;
        r_pend   <= 1'b0;
      end else if (w_accept) begin
        r_pend <= 1'b1;
      end
    end
  end

`ifdef DISP_PDM_EN
  logic w_pdm_carry;

  // accumulates every clk regardless of display enable
  pdm_gen #(
    .PDM_W(PDM_W)
  ) u_pdm_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (1'b1),
    .level (disp_pdm),
    .out   (w_pdm_carry)
  );

  assign w_blank_nxt = ~w_pdm_carry | ~disp_ena;
`else
  logic w_pdm_unused;

  assign w_pdm_unused = ^disp_pdm;
  assign w_blank_nxt  = ~disp_ena;
`endif

  assign frm_ready  = ~r_pend;
  assign disp_sclk  = r_sclk;
  assign disp_sin   = r_sin;
  assign disp_lat   = r_lat;
  assign disp_blank = r_blank;
  assign busy       = r_busy;
  assign ovr        = r_ovr;

endmodule

// File: tb/tb_disp_chain.sv
// Scoreboard bench for disp_chain: expected frames are queued at each tick and a monitor
// reassembles the bit stream from sclk rising edges and compares at each latch pulse.
module tb_disp_chain;

  localparam int FW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tsc_1ppus = 1'b0;
  logic          disp_ena = 1'b0;
  logic [7:0]    disp_pdm = 8'h00;
  logic [FW-1:0] frm_data = '0;
  logic          frm_valid = 1'b0;
  logic          frm_ready, disp_sclk, disp_sin, disp_lat, disp_blank, busy, ovr;

  int n_cmp = 0;
  int n_err = 0;

  logic [FW-1:0] exp_q[$];
  int            total_rises = 0;

  localparam logic [FW-1:0] F1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [FW-1:0] F2 = 64'hDEAD_BEEF_0F0F_A5A5;
  localparam logic [FW-1:0] F3 = 64'h8000_0000_0000_0001;
  localparam logic [FW-1:0] F4 = 64'hFFFF_0000_1234_5678;
  localparam logic [FW-1:0] F5 = 64'h5555_AAAA_3C3C_C3C3;

  disp_chain #(
    .N_DEV(4),
    .SCLK_DIV(2),
    .PDM_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tsc_1ppus  (tsc_1ppus),
    .disp_ena   (disp_ena),
    .disp_pdm   (disp_pdm),
    .frm_data   (frm_data),
    .frm_valid  (frm_valid),
    .frm_ready  (frm_ready),
    .disp_sclk  (disp_sclk),
    .disp_sin   (disp_sin),
    .disp_lat   (disp_lat),
    .disp_blank (disp_blank),
    .busy       (busy),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    tsc_1ppus = 1'b1;
    @(negedge clk);
    tsc_1ppus = 1'b0;
  endtask

  task automatic offer(input logic [FW-1:0] f);
    frm_data  = f;
    frm_valid = 1'b1;
    @(negedge clk);
    frm_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(n < 1000), 64'd1);
  endtask

  // Monitor: reassembles frames and checks latch width, busy length and sin timing.
  logic [FW-1:0] cap;
  int            nbits, lat_len, busy_len;
  logic          prev_sclk, prev_lat, prev_busy, prev_sin;

  always @(negedge clk) begin
    if (!rst_n) begin
      cap = '0; nbits = 0; lat_len = 0; busy_len = 0;
      prev_sclk = 1'b0; prev_lat = 1'b0; prev_busy = 1'b0; prev_sin = 1'b0;
    end else begin
      if (disp_sin !== prev_sin)
        check("sin_edge", 64'((prev_sclk && !disp_sclk) || (busy && !prev_busy)), 64'd1);
      if (disp_sclk && !prev_sclk) begin
        cap = {cap[FW-2:0], disp_sin};
        nbits++;
        total_rises++;
      end
      if (disp_lat) lat_len++;
      if (disp_lat && !prev_lat) begin
        check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [FW-1:0] f;
          f = exp_q.pop_front();
          check("frame_bits", cap, f);
          check("frame_len", 64'(nbits), 64'(FW));
        end
        cap = '0;
        nbits = 0;
      end
      if (!disp_lat && prev_lat) begin
        check("lat_len", 64'(lat_len), 64'd2);
        lat_len = 0;
      end
      if (busy) busy_len++;
      if (!busy && prev_busy) begin
        check("busy_len", 64'(busy_len), 64'd258);
        busy_len = 0;
      end
      prev_sclk = disp_sclk;
      prev_lat  = disp_lat;
      prev_busy = busy;
      prev_sin  = disp_sin;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cnt, rises0;
    logic prev;

    repeat (3) @(negedge clk);
    check("rst_sclk",  64'(disp_sclk),  64'd0);
    check("rst_sin",   64'(disp_sin),   64'd0);
    check("rst_lat",   64'(disp_lat),   64'd0);
    check("rst_blank", 64'(disp_blank), 64'd1);
    check("rst_ready", 64'(frm_ready),  64'd1);
    check("rst_busy",  64'(busy),       64'd0);
    check("rst_ovr",   64'(ovr),        64'd0);
    rst_n = 1'b1;
    disp_ena = 1'b1;
    repeat (3) @(negedge clk);

    // First frame: handshake, MSB-first stream, sclk phase.
    offer(F1);
    check("ready_after_accept", 64'(frm_ready), 64'd0);
    repeat (2) @(negedge clk);
    exp_q.push_back(F1);
    tick();
    check("ready_after_start", 64'(frm_ready), 64'd1);
    check("busy_after_tick",   64'(busy),      64'd1);
    check("first_sin",         64'(disp_sin),  64'(F1[FW-1]));
    @(negedge clk);
    check("sclk_low_phase", 64'(disp_sclk), 64'd0);
    @(negedge clk);
    check("first_sclk_rise", 64'(disp_sclk), 64'd1);
    wait_idle();

    // Refresh without new frame, tick in the first cycle after busy falls.
    exp_q.push_back(F1);
    tick();
    check("refresh_busy", 64'(busy), 64'd1);
    wait_idle();

    // Overrun: tick at cycle 100 of a frame.
    exp_q.push_back(F1);
    tick();
    repeat (98) @(negedge clk);
    tick();
    check("ovr_pulse", 64'(ovr), 64'd1);
    @(negedge clk);
    check("ovr_one_cycle", 64'(ovr),  64'd0);
    check("ovr_busy",      64'(busy), 64'd1);
    wait_idle();

    // Second offer while pending is held off until the next frame start.
    frm_data = F2;
    frm_valid = 1'b1;
    @(negedge clk);
    check("pend_ready_low", 64'(frm_ready), 64'd0);
    frm_data = F3;
    repeat (5) @(negedge clk);
    check("pend_still_low", 64'(frm_ready), 64'd0);
    exp_q.push_back(F2);
    tick();
    check("pend_release", 64'(frm_ready), 64'd1);
    @(negedge clk);
    frm_valid = 1'b0;
    check("f3_accepted", 64'(frm_ready), 64'd0);
    wait_idle();
    exp_q.push_back(F3);
    tick();
    wait_idle();

    // Accept and start in the same cycle: old active goes out, new one waits.
    frm_data = F4;
    frm_valid = 1'b1;
    exp_q.push_back(F3);
    tick();
    frm_valid = 1'b0;
    check("same_cycle_pend", 64'(frm_ready), 64'd0);
    wait_idle();
    exp_q.push_back(F4);
    tick();
    check("same_cycle_release", 64'(frm_ready), 64'd1);
    wait_idle();

    // Display disabled: blank forced, ticks ignored.
    disp_ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ena_low_blank", 64'(disp_blank), 64'd1);
    tick();
    check("ena_low_no_start", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("ena_low_idle", 64'(busy), 64'd0);
    disp_ena = 1'b1;
    repeat (2) @(negedge clk);

`ifdef DISP_PDM_EN
    disp_pdm = 8'hAA;
    repeat (4) @(negedge clk);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (!disp_blank) cnt++;
    end
    check("pdm_aa_unblanked", 64'(cnt), 64'd170);
    disp_pdm = 8'h00;
    repeat (4) @(negedge clk);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (disp_blank) cnt++;
    end
    check("pdm_00_blanked", 64'(cnt), 64'd256);
    disp_pdm = 8'h80;
    repeat (4) @(negedge clk);
    prev = disp_blank;
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (disp_blank !== prev) cnt++;
      prev = disp_blank;
    end
    check("pdm_80_toggles", 64'(cnt), 64'd16);
`else
    check("ena_high_unblank", 64'(disp_blank), 64'd0);
`endif

    // Reset mid-shift discards the pending frame and stops the chain at once.
    tick();
    offer(F5);
    check("pre_rst_pend", 64'(frm_ready), 64'd0);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sclk",  64'(disp_sclk),  64'd0);
    check("mid_rst_lat",   64'(disp_lat),   64'd0);
    check("mid_rst_blank", 64'(disp_blank), 64'd1);
    check("mid_rst_busy",  64'(busy),       64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(frm_ready), 64'd1);
    rises0 = total_rises;
    repeat (300) @(negedge clk);
    check("post_rst_no_shift", 64'(total_rises - rises0), 64'd0);
    exp_q.push_back('0);
    tick();
    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
